tiny_alu_seq: RTL and testbench
===============================

Name: tiny_alu_seq

Overview:
Sequencer stage placed directly upstream and downstream of tiny_alu. It accepts ALU commands on a valid/ready interface and drives tiny_alu's a/b/op pins with the timing that tiny_alu requires. It tracks the 2-cycle ALU latency, captures y into a result FIFO, and presents results on a valid/ready interface. Credit-based flow control guarantees the result FIFO can never overflow.

Parameters:
W, 4, operand/result width; must match tiny_alu (fixed 4 in current use)
DEPTH, 4, result FIFO entries; also the credit limit; power of 2, >=2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid&&cmd_ready
cmd_op  in  1  0=XOR, 1=AND
cmd_a  in  W  operand a
cmd_b  in  W  operand b
alu_a  out  W  to tiny_alu.a
alu_b  out  W  to tiny_alu.b
alu_op  out  1  to tiny_alu.op
alu_y  in  W  from tiny_alu.y
res_valid  out  1  result FIFO non-empty
res_ready  in  1  consumer takes head when res_valid&&res_ready
res_data  out  W  FIFO head
busy  out  1  any command in flight or any result buffered

Behaviour:
- Reset (async, immediate): alu_a=0, alu_b=0, alu_op=0, in-flight tags cleared, FIFO emptied (ptrs=0, count=0), res_valid=0, res_data=0, busy=0. cmd_ready=1 combinationally once rst deasserts.
- tiny_alu timing: a/b are registered at edge E; op is sampled at edge E+1 together with a_reg/b_reg; y is valid after E+1.
- Issue: on accept at edge E0:
  - alu_a/alu_b <= cmd_a/cmd_b (visible after E0, captured by the ALU at E1).
  - cmd_op is held in op_pipe; alu_op <= op_pipe at E1, so the ALU samples it at E2.
  - y is valid after E2. The collector pushes alu_y into the FIFO at E3.
  - Latency: accept edge to res_valid = 3 clk edges.
- 3-bit valid shift register tracks in-flight commands. Bit2 set means push alu_y at this edge.
- When no command is accepted, alu_a/alu_b/alu_op hold their last values. The garbage y that results is never pushed, because its tag bit is 0.
- Back-to-back: one accept per cycle sustained; op_pipe/alu_op update every accept so consecutive commands never mix ops.
- Credits: total = popcount(in-flight tags) + fifo_count. cmd_ready = (total < DEPTH). It depends on registered state only; it does not look ahead to a same-cycle pop.
- Because of credits, a push never hits a full FIFO. Any push while full is a design error; flag it with an assertion.
- FIFO: circular, wrap-around pointers log2(DEPTH) bits, separate count 0..DEPTH.
  - Push and pop in the same cycle: count is unchanged, both pointers advance.
  - Pop when empty is ignored.
  - res_data = mem[rd_ptr] when non-empty, else 0.
- busy = |tags || fifo_count!=0.
- Reset mid-operation: in-flight commands and buffered results are discarded. No result is emitted after reset for a command accepted before it.
- Width: results are exactly W bits; no extension.

Decomposition:
- Shared package tiny_alu_pkg: W=4, OP_XOR=1'b0, OP_AND=1'b1, ALU_LAT=2.
- One sub-module is natural: tiny_alu_rfifo (parameterised W/DEPTH synchronous FIFO with async rst, push/pop/count/empty/full).
- Credit counter, tag shifter and op_pipe stay in tiny_alu_seq.
- Bench instantiates tiny_alu_seq plus tiny_alu and connects the alu_* pins.

Test Plan:
- Single command, after reset: op=0 a=5 b=3, res_ready=1 → res_valid rises 3 edges after accept, res_data=6; busy drops the cycle after pop.
- Back-to-back: (0,5,3), (1,C,A), (0,F,F), (1,7,E) on 4 consecutive cycles → results 6, 8, 0, 6 in order, one per cycle, no bubbles.
- Backpressure: res_ready=0, offer 6 commands (1,F,1…) → exactly 4 accepted, then cmd_ready=0. Raise res_ready → 4 results=1 delivered. cmd_ready reasserts the cycle after the first pop; the remaining 2 commands then complete.
- Full with simultaneous pop: FIFO holding 4, res_ready=1, cmd_valid=1 → the first pop frees one credit, the next accept proceeds, and count never exceeds 4 (assertion clean).
- Reset mid-flight: accept (0,9,6), assert rst 1 edge later → all outputs 0 immediately, no result ever appears. The post-reset command (1,9,6) returns 0.
- Idle hold: no cmd_valid for 10 cycles after (1,3,3) → alu_a=3, alu_b=3, alu_op=1 held; exactly one result (3) emitted.

Source files
------------

// File: rtl/tiny_alu_pkg.sv
// Shared constants, tag type and popcount helper for the tiny_alu datapath.
package tiny_alu_pkg;

  localparam int   W       = 4;
  localparam logic OP_XOR  = 1'b0;
  localparam logic OP_AND  = 1'b1;
  localparam int   ALU_LAT = 2;
  localparam int   TAG_W   = ALU_LAT + 1;

  typedef logic [TAG_W-1:0] tag_t;

  function automatic logic [1:0] tag_popcount(input tag_t v);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < TAG_W; i++) begin
      n = n + {1'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tiny_alu.sv
// Two-cycle ALU: operands registered at edge E, op sampled and y registered at E+1.
module tiny_alu
  import tiny_alu_pkg::*;
#(
  parameter int W = tiny_alu_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] y
);

  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] f_s;

  // operand capture stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= {W{1'b0}};
      b_r <= {W{1'b0}};
    end else begin
      a_r <= a;
      b_r <= b;
    end
  end

  // function select
  always_comb begin
    f_s = {W{1'b0}};
    case (op)
      OP_XOR:  f_s = a_r ^ b_r;
      OP_AND:  f_s = a_r & b_r;
      default: f_s = {W{1'b0}};
    endcase
  end

  // result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= {W{1'b0}};
    end else begin
      y <= f_s;
    end
  end

endmodule

// File: rtl/tiny_alu_rfifo.sv
// Circular result FIFO with wrap-around pointers and a separate occupancy count.
module tiny_alu_rfifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // storage write; contents are only observed through head when non-empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // head is forced to zero while empty so stale entries never leak out
  always_comb begin
    head = {W{1'b0}};
    if (!empty) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = {W{1'b0}};
    end
  end

endmodule

// File: rtl/tiny_alu_seq_chk.sv
// Invariant checker for the sequencer: credits must keep the FIFO from overflowing.
module tiny_alu_seq_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   push,
  input logic                   full,
  input logic [$clog2(DEPTH):0] count
);

  // sampled every edge outside reset
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full))
        else $error("tiny_alu_seq: result push while FIFO full");
      assert (count <= ($clog2(DEPTH)+1)'(DEPTH))
        else $error("tiny_alu_seq: FIFO count %0d exceeds depth", count);
    end
  end

endmodule

// File: rtl/tiny_alu_seq.sv
// Command sequencer around tiny_alu: issues a/b/op, tracks latency with tags, buffers y.
module tiny_alu_seq
  import tiny_alu_pkg::*;
#(
  parameter int W     = tiny_alu_pkg::W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_op,
  input  logic [W-1:0] alu_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  tag_t          tags_r;
  logic          op_pipe_r;
  logic          accept_s;
  logic          push_s;
  logic [AW:0]   count_s;
  logic          empty_s;
  logic          full_s;
  logic [CW-1:0] total_s;

  // credits come from registered state only; a same-cycle pop is not anticipated
  assign total_s   = CW'(tag_popcount(tags_r)) + CW'(count_s);
  assign cmd_ready = (total_s < CW'(DEPTH));
  assign accept_s  = cmd_valid && cmd_ready;
  assign push_s    = tags_r[TAG_W-1];
  assign res_valid = !empty_s;
  assign busy      = (|tags_r) || (count_s != {(AW+1){1'b0}});

  // in-flight tags; the top bit lines up with y being valid for this command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_r <= {TAG_W{1'b0}};
    end else begin
      tags_r <= {tags_r[TAG_W-2:0], accept_s};
    end
  end

  // operands go out at the accept edge, op one edge later to meet the ALU's sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= {W{1'b0}};
      alu_b     <= {W{1'b0}};
      op_pipe_r <= 1'b0;
      alu_op    <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_a     <= cmd_a;
        alu_b     <= cmd_b;
        op_pipe_r <= cmd_op;
      end
      alu_op <= op_pipe_r;
    end
  end

  tiny_alu_rfifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_rfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (alu_y),
    .pop       (res_ready),
    .head      (res_data),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  tiny_alu_seq_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .full  (full_s),
    .count (count_s)
  );

endmodule

// File: tb/tb_tiny_alu_seq.sv
// Directed bench for tiny_alu_seq driving a real tiny_alu; results scored against hand values.
module tb_tiny_alu_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_op;
  logic [3:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       busy;

  int         total;
  int         bad;
  int         nacc;
  int         npop;
  int         want_acc;
  int         base_acc;
  int         base_pop;
  logic [3:0] cur_exp;
  logic [3:0] expq[$];

  tiny_alu_seq #(.W(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  tiny_alu #(.W(4)) u_alu (
    .clk (clk),
    .rst (rst),
    .a   (alu_a),
    .b   (alu_b),
    .op  (alu_op),
    .y   (alu_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v)
      else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
  endtask

  task automatic offer(input logic op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] exp_v, input int n);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cur_exp   = exp_v;
    want_acc  = nacc + n;
    cmd_valid = 1'b1;
  endtask

  // one clock: score any pop, record any accept, sample #1 after the edge
  task automatic tick();
    logic acc;
    logic pop;
    acc = cmd_valid && cmd_ready;
    pop = res_valid && res_ready;
    if (pop) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $error("FAIL spurious_result: got %0h want none", res_data);
      end else begin
        chk("res_data", 8'(res_data), 8'(expq.pop_front()));
      end
      npop++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      expq.push_back(cur_exp);
      nacc++;
      if (nacc >= want_acc) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    total = 0; bad = 0; nacc = 0; npop = 0; want_acc = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0;
    res_ready = 1'b0; cur_exp = 4'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_a", 8'(alu_a), 8'h0);
    chk("rst_alu_op", 8'(alu_op), 8'h0);
    chk("rst_res_valid", 8'(res_valid), 8'h0);
    chk("rst_res_data", 8'(res_data), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 8'(cmd_ready), 8'h1);

    // single command: 5 ^ 3 = 6, visible 3 edges after accept
    res_ready = 1'b1;
    offer(1'b0, 4'h5, 4'h3, 4'h6, 1);
    tick();
    chk("single_alu_a", 8'(alu_a), 8'h5);
    chk("single_alu_b", 8'(alu_b), 8'h3);
    chk("single_busy", 8'(busy), 8'h1);
    tick();
    chk("single_rv_e1", 8'(res_valid), 8'h0);
    tick();
    chk("single_rv_e2", 8'(res_valid), 8'h0);
    tick();
    chk("single_rv_e3", 8'(res_valid), 8'h1);
    chk("single_data_e3", 8'(res_data), 8'h6);
    tick();
    chk("single_rv_after_pop", 8'(res_valid), 8'h0);
    chk("single_busy_after_pop", 8'(busy), 8'h0);

    // back-to-back: 6, 8, 0, 6 with no bubbles
    base_acc = nacc;
    offer(1'b0, 4'h5, 4'h3, 4'h6, 1); tick();
    offer(1'b1, 4'hC, 4'hA, 4'h8, 1); tick();
    offer(1'b0, 4'hF, 4'hF, 4'h0, 1); tick();
    offer(1'b1, 4'h7, 4'hE, 4'h6, 1); tick();
    chk("b2b_accepts", 8'(nacc - base_acc), 8'd4);
    chk("b2b_rv0", 8'(res_valid), 8'h1);
    chk("b2b_d0", 8'(res_data), 8'h6);
    tick();
    chk("b2b_rv1", 8'(res_valid), 8'h1);
    chk("b2b_d1", 8'(res_data), 8'h8);
    tick();
    chk("b2b_rv2", 8'(res_valid), 8'h1);
    chk("b2b_d2", 8'(res_data), 8'h0);
    tick();
    chk("b2b_rv3", 8'(res_valid), 8'h1);
    chk("b2b_d3", 8'(res_data), 8'h6);
    tick();
    chk("b2b_rv_end", 8'(res_valid), 8'h0);

    // backpressure: only 4 credits, then drain and finish the other 2
    res_ready = 1'b0;
    base_acc = nacc;
    base_pop = npop;
    offer(1'b1, 4'hF, 4'h1, 4'h1, 6);
    repeat (8) tick();
    chk("bp_accepts_stalled", 8'(nacc - base_acc), 8'd4);
    chk("bp_cmd_ready_low", 8'(cmd_ready), 8'h0);
    chk("bp_res_valid", 8'(res_valid), 8'h1);
    res_ready = 1'b1;
    #1;
    chk("bp_ready_before_pop", 8'(cmd_ready), 8'h0);
    tick();
    chk("bp_ready_after_pop", 8'(cmd_ready), 8'h1);
    repeat (15) tick();
    chk("bp_accepts_total", 8'(nacc - base_acc), 8'd6);
    chk("bp_pops_total", 8'(npop - base_pop), 8'd6);
    chk("bp_busy_end", 8'(busy), 8'h0);

    // full FIFO with simultaneous pop and offer
    res_ready = 1'b0;
    base_acc = nacc;
    base_pop = npop;
    offer(1'b0, 4'h1, 4'h2, 4'h3, 4);
    repeat (7) tick();
    chk("full_cmd_ready", 8'(cmd_ready), 8'h0);
    chk("full_busy", 8'(busy), 8'h1);
    res_ready = 1'b1;
    offer(1'b0, 4'hA, 4'h5, 4'hF, 1);
    tick();
    chk("full_no_accept_yet", 8'(nacc - base_acc), 8'd4);
    chk("full_ready_after_pop", 8'(cmd_ready), 8'h1);
    tick();
    chk("full_accept_after_pop", 8'(nacc - base_acc), 8'd5);
    repeat (8) tick();
    chk("full_pops", 8'(npop - base_pop), 8'd5);
    chk("full_q_empty", 8'(expq.size()), 8'd0);
    chk("full_busy_end", 8'(busy), 8'h0);

    // reset mid-flight discards the command
    offer(1'b0, 4'h9, 4'h6, 4'hF, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_alu_a", 8'(alu_a), 8'h0);
    chk("mrst_alu_b", 8'(alu_b), 8'h0);
    chk("mrst_busy", 8'(busy), 8'h0);
    chk("mrst_res_valid", 8'(res_valid), 8'h0);
    expq.delete();
    tick();
    rst = 1'b0;
    base_pop = npop;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_no_result", 8'(res_valid), 8'h0);
    end
    offer(1'b1, 4'h9, 4'h6, 4'h0, 1);
    repeat (6) tick();
    chk("mrst_post_pops", 8'(npop - base_pop), 8'd1);
    chk("mrst_q_empty", 8'(expq.size()), 8'd0);

    // idle hold after a single AND 3,3
    base_pop = npop;
    offer(1'b1, 4'h3, 4'h3, 4'h3, 1);
    tick();
    repeat (10) tick();
    chk("hold_alu_a", 8'(alu_a), 8'h3);
    chk("hold_alu_b", 8'(alu_b), 8'h3);
    chk("hold_alu_op", 8'(alu_op), 8'h1);
    chk("hold_pops", 8'(npop - base_pop), 8'd1);
    chk("hold_res_valid", 8'(res_valid), 8'h0);
    chk("hold_busy", 8'(busy), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
